// File: rtl/udp_tx_pkt_arbiter.sv
// udp_tx_pkt_arbiter
// Merges two AXI-Stream packet sources (s0 = XDMA H2C, s1 = perf-monitor
// generator) onto one UDP TX stream. Arbitration is packet-atomic round-robin
// with a programmable idle gap after each packet for rate pacing.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no owner; pick a requester (round-robin on a tie) if enabled
// BUSY  | owner's stream is muxed straight through until its tlast beat
// GAP   | pacing gap; nothing flows for gap_cycles cycles
module udp_tx_pkt_arbiter #(
    parameter int TDATA_WIDTH = 512,
    parameter int TKEEP_WIDTH = 64,
    parameter int TUSER_WIDTH = 1,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   enable,
    input  logic [CNT_WIDTH-1:0]   gap_cycles,

    input  logic                   s0_axis_tvalid,
    output logic                   s0_axis_tready,
    input  logic                   s0_axis_tlast,
    input  logic [TDATA_WIDTH-1:0] s0_axis_tdata,
    input  logic [TKEEP_WIDTH-1:0] s0_axis_tkeep,
    input  logic [TUSER_WIDTH-1:0] s0_axis_tuser,

    input  logic                   s1_axis_tvalid,
    output logic                   s1_axis_tready,
    input  logic                   s1_axis_tlast,
    input  logic [TDATA_WIDTH-1:0] s1_axis_tdata,
    input  logic [TKEEP_WIDTH-1:0] s1_axis_tkeep,
    input  logic [TUSER_WIDTH-1:0] s1_axis_tuser,

    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [TKEEP_WIDTH-1:0] m_axis_tkeep,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,

    output logic [1:0]             grant_out,
    output logic [CNT_WIDTH-1:0]   pkt_count0,
    output logic [CNT_WIDTH-1:0]   pkt_count1
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [1:0]           grant, grant_nxt;
    logic                 last_grant, last_grant_nxt;
    logic [CNT_WIDTH-1:0] gap_cnt, gap_cnt_nxt;
    logic                 owner;
    logic                 xfer_last;

    // grant is one-hot while BUSY, so bit 1 alone identifies the owner
    assign owner     = grant[1];
    assign grant_out = grant;
    assign xfer_last = (state == ST_BUSY) && m_axis_tvalid && m_axis_tready && m_axis_tlast;

    // State register; last_grant resets to 1 so s0 wins the first tie
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            grant      <= 2'b00;
            last_grant <= 1'b1;
            gap_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            gap_cnt    <= gap_cnt_nxt;
        end
    end

    // Next-state: registered arbitration in IDLE, release on tlast, gap count-down
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        gap_cnt_nxt    = gap_cnt;
        case (state)
            ST_IDLE: begin
                if (enable && (s0_axis_tvalid || s1_axis_tvalid)) begin
                    state_nxt = ST_BUSY;
                    if (s0_axis_tvalid && s1_axis_tvalid) begin
                        grant_nxt = last_grant ? 2'b01 : 2'b10;
                    end else begin
                        grant_nxt = s0_axis_tvalid ? 2'b01 : 2'b10;
                    end
                end
            end
            ST_BUSY: begin
                if (xfer_last) begin
                    last_grant_nxt = owner;
                    grant_nxt      = 2'b00;
                    if (gap_cycles == '0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        gap_cnt_nxt = gap_cycles;
                        state_nxt   = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt <= CNT_WIDTH'(1)) begin
                    gap_cnt_nxt = '0;
                    state_nxt   = ST_IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt - CNT_WIDTH'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = 2'b00;
            end
        endcase
    end

    // Zero-latency datapath mux; everything is driven to 0 outside BUSY
    always_comb begin
        m_axis_tvalid  = 1'b0;
        m_axis_tlast   = 1'b0;
        m_axis_tdata   = '0;
        m_axis_tkeep   = '0;
        m_axis_tuser   = '0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        if (state == ST_BUSY) begin
            if (grant[0]) begin
                m_axis_tvalid  = s0_axis_tvalid;
                m_axis_tlast   = s0_axis_tlast;
                m_axis_tdata   = s0_axis_tdata;
                m_axis_tkeep   = s0_axis_tkeep;
                m_axis_tuser   = s0_axis_tuser;
                s0_axis_tready = m_axis_tready;
            end else if (grant[1]) begin
                m_axis_tvalid  = s1_axis_tvalid;
                m_axis_tlast   = s1_axis_tlast;
                m_axis_tdata   = s1_axis_tdata;
                m_axis_tkeep   = s1_axis_tkeep;
                m_axis_tuser   = s1_axis_tuser;
                s1_axis_tready = m_axis_tready;
            end
        end
    end

    // Per-source packet counters, bumped on each accepted tlast beat; wrap freely
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pkt_count0 <= '0;
            pkt_count1 <= '0;
        end else if (xfer_last) begin
            if (owner) begin
                pkt_count1 <= pkt_count1 + CNT_WIDTH'(1);
            end else begin
                pkt_count0 <= pkt_count0 + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_udp_tx_pkt_arbiter.sv
// Directed testbench for udp_tx_pkt_arbiter. Two simple packet-source models
// drive s0/s1; every cycle's outputs are captured into o_* for the tests.
module tb_udp_tx_pkt_arbiter;

    logic         clk;
    logic         rst_n;
    logic         enable;
    logic [31:0]  gap_cycles;
    logic         s0_axis_tvalid, s0_axis_tready, s0_axis_tlast;
    logic [511:0] s0_axis_tdata;
    logic [63:0]  s0_axis_tkeep;
    logic [0:0]   s0_axis_tuser;
    logic         s1_axis_tvalid, s1_axis_tready, s1_axis_tlast;
    logic [511:0] s1_axis_tdata;
    logic [63:0]  s1_axis_tkeep;
    logic [0:0]   s1_axis_tuser;
    logic         m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic [0:0]   m_axis_tuser;
    logic [1:0]   grant_out;
    logic [31:0]  pkt_count0, pkt_count1;

    int errors = 0;
    int checks = 0;

    // source models
    int pkts_left[2];
    int len[2];
    int beat_idx[2];
    int pkt_idx[2];

    // controls applied at the next negedge
    logic        n_rst, n_en, n_ready;
    logic [31:0] n_gap;

    // per-cycle observations
    logic [1:0]   o_grant;
    logic         o_mv, o_ml, o_s0r, o_s1r;
    logic [511:0] o_md;
    logic [63:0]  o_mk;
    logic [31:0]  o_pc0, o_pc1;
    int           bad_ready;
    int           cyc;
    int           done_q[$];
    int           t_q[$];

    udp_tx_pkt_arbiter dut (
        .CLK(clk), .RST_N(rst_n), .enable(enable), .gap_cycles(gap_cycles),
        .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready), .s0_axis_tlast(s0_axis_tlast),
        .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep), .s0_axis_tuser(s0_axis_tuser),
        .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready), .s1_axis_tlast(s1_axis_tlast),
        .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep), .s1_axis_tuser(s1_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
        .grant_out(grant_out), .pkt_count0(pkt_count0), .pkt_count1(pkt_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] mk_data(input int src, input int pkt, input int beat);
        logic [31:0] w;
        w = {8'(src), 8'(pkt), 8'(beat), 8'h5A};
        return {16{w}};
    endfunction

    function automatic logic [63:0] mk_keep(input int beat);
        logic [63:0] all_ones;
        all_ones = '1;
        return all_ones >> beat;
    endfunction

    task automatic src_clear();
        for (int k = 0; k < 2; k++) begin
            pkts_left[k] = 0;
            len[k]       = 1;
            beat_idx[k]  = 0;
            pkt_idx[k]   = 0;
        end
    endtask

    task automatic advance(input int k);
        if (beat_idx[k] == len[k] - 1) begin
            beat_idx[k]  = 0;
            pkt_idx[k]   = pkt_idx[k] + 1;
            pkts_left[k] = pkts_left[k] - 1;
        end else begin
            beat_idx[k] = beat_idx[k] + 1;
        end
    endtask

    task automatic drive_sources();
        s0_axis_tvalid = (pkts_left[0] > 0);
        s0_axis_tlast  = s0_axis_tvalid && (beat_idx[0] == len[0] - 1);
        s0_axis_tdata  = s0_axis_tvalid ? mk_data(0, pkt_idx[0], beat_idx[0]) : '0;
        s0_axis_tkeep  = s0_axis_tvalid ? mk_keep(beat_idx[0]) : '0;
        s0_axis_tuser  = s0_axis_tvalid ? 1'(beat_idx[0] & 1) : 1'b0;
        s1_axis_tvalid = (pkts_left[1] > 0);
        s1_axis_tlast  = s1_axis_tvalid && (beat_idx[1] == len[1] - 1);
        s1_axis_tdata  = s1_axis_tvalid ? mk_data(1, pkt_idx[1], beat_idx[1]) : '0;
        s1_axis_tkeep  = s1_axis_tvalid ? mk_keep(beat_idx[1]) : '0;
        s1_axis_tuser  = s1_axis_tvalid ? 1'(beat_idx[1] & 1) : 1'b0;
    endtask

    // One clock: drive at negedge, observe 1 ns later, let the posedge act
    task automatic cycle();
        logic f0, f1;
        @(negedge clk);
        rst_n         = n_rst;
        enable        = n_en;
        m_axis_tready = n_ready;
        gap_cycles    = n_gap;
        drive_sources();
        #1;
        o_grant = grant_out;   o_mv  = m_axis_tvalid;  o_ml  = m_axis_tlast;
        o_md    = m_axis_tdata; o_mk = m_axis_tkeep;
        o_s0r   = s0_axis_tready; o_s1r = s1_axis_tready;
        o_pc0   = pkt_count0;  o_pc1 = pkt_count1;
        f0 = s0_axis_tvalid && s0_axis_tready;
        f1 = s1_axis_tvalid && s1_axis_tready;
        if ((grant_out == 2'b01 && s1_axis_tready) || (grant_out == 2'b10 && s0_axis_tready))
            bad_ready++;
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            done_q.push_back(f1 ? 1 : 0);
            t_q.push_back(cyc);
        end
        @(posedge clk);
        if (f0) advance(0);
        if (f1) advance(1);
        cyc++;
    endtask

    task automatic test_reset();
        src_clear();
        pkts_left[0] = 1; len[0] = 2;
        pkts_left[1] = 1; len[1] = 2;
        n_rst = 1'b0; n_en = 1'b1; n_ready = 1'b1; n_gap = 0;
        cycle();
        cycle();
        checks++; if (o_grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", o_grant); end
        checks++; if (o_s0r !== 1'b0 || o_s1r !== 1'b0) begin errors++; $display("FAIL reset_ready: got s0=%b s1=%b expected 0 0", o_s0r, o_s1r); end
        checks++; if (o_mv !== 1'b0 || o_ml !== 1'b0 || o_md !== '0 || o_mk !== '0) begin errors++; $display("FAIL reset_m_out: got valid=%b last=%b keep=%h expected all 0", o_mv, o_ml, o_mk); end
        checks++; if (o_pc0 !== 0 || o_pc1 !== 0) begin errors++; $display("FAIL reset_counts: got %0d %0d expected 0 0", o_pc0, o_pc1); end
        src_clear();
    endtask

    task automatic test_single_packet();
        n_rst = 1'b1; n_en = 1'b1; n_ready = 1'b1; n_gap = 0;
        pkts_left[0] = 1; len[0] = 4;
        cycle();
        checks++; if (o_grant !== 2'b00 || o_s0r !== 1'b0) begin errors++; $display("FAIL single_req_cycle: got grant=%b s0_ready=%b expected 00 0", o_grant, o_s0r); end
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++; if (o_grant !== 2'b01 || o_mv !== 1'b1) begin errors++; $display("FAIL single_beat%0d_grant: got grant=%b valid=%b expected 01 1", i, o_grant, o_mv); end
            checks++; if (o_md !== mk_data(0, 0, i) || o_mk !== mk_keep(i)) begin errors++; $display("FAIL single_beat%0d_data: got %h expected %h", i, o_md[31:0], mk_data(0, 0, i) & 512'hFFFFFFFF); end
            checks++; if (o_ml !== (i == 3)) begin errors++; $display("FAIL single_beat%0d_last: got %b expected %b", i, o_ml, (i == 3)); end
        end
        cycle();
        checks++; if (o_grant !== 2'b00 || o_mv !== 1'b0 || o_md !== '0) begin errors++; $display("FAIL single_after: got grant=%b valid=%b expected 00 0", o_grant, o_mv); end
        checks++; if (o_pc0 !== 1 || o_pc1 !== 0) begin errors++; $display("FAIL single_count: got %0d %0d expected 1 0", o_pc0, o_pc1); end
    endtask

    task automatic test_back_to_back();
        int budget;
        src_clear();
        n_rst = 1'b0;
        cycle();
        n_rst = 1'b1;
        done_q.delete(); t_q.delete(); bad_ready = 0;
        pkts_left[0] = 4; len[0] = 2;
        pkts_left[1] = 4; len[1] = 2;
        budget = 0;
        while (done_q.size() < 8 && budget < 60) begin
            cycle();
            budget++;
        end
        checks++; if (done_q.size() != 8) begin errors++; $display("FAIL b2b_timeout: got %0d packets expected 8", done_q.size()); end
        for (int i = 0; i < 8 && i < done_q.size(); i++) begin
            checks++; if (done_q[i] != (i % 2)) begin errors++; $display("FAIL b2b_order%0d: got src %0d expected %0d", i, done_q[i], i % 2); end
        end
        if (t_q.size() == 8) begin
            checks++; if (t_q[7] - t_q[0] != 21) begin errors++; $display("FAIL b2b_spacing: got %0d cycles expected 21", t_q[7] - t_q[0]); end
        end
        cycle();
        checks++; if (o_pc0 !== 4 || o_pc1 !== 4) begin errors++; $display("FAIL b2b_counts: got %0d %0d expected 4 4", o_pc0, o_pc1); end
        checks++; if (bad_ready != 0) begin errors++; $display("FAIL b2b_nonowner_ready: got %0d cycles expected 0", bad_ready); end
    endtask

    task automatic test_gap();
        int budget;
        src_clear();
        done_q.delete(); t_q.delete();
        n_gap = 5;
        pkts_left[0] = 3; len[0] = 1;
        budget = 0;
        while (t_q.size() < 3 && budget < 60) begin
            cycle();
            if (t_q.size() == 1) n_gap = 2;
            budget++;
        end
        checks++; if (t_q.size() != 3) begin errors++; $display("FAIL gap_timeout: got %0d packets expected 3", t_q.size()); end
        if (t_q.size() == 3) begin
            checks++; if (t_q[1] - t_q[0] != 7) begin errors++; $display("FAIL gap_period5: got %0d expected 7", t_q[1] - t_q[0]); end
            checks++; if (t_q[2] - t_q[1] != 4) begin errors++; $display("FAIL gap_period2: got %0d expected 4", t_q[2] - t_q[1]); end
        end
    endtask

    task automatic test_stall();
        int exp_beat[5] = '{0, 1, 1, 2, 2};
        logic [31:0] base;
        src_clear();
        n_gap = 0; n_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        base = o_pc1;
        pkts_left[1] = 1; len[1] = 3;
        cycle();
        for (int i = 0; i < 5; i++) begin
            n_ready = (i % 2 == 0);
            cycle();
            checks++; if (o_grant !== 2'b10 || o_mv !== 1'b1 || o_md !== mk_data(1, 0, exp_beat[i])) begin errors++; $display("FAIL stall_c%0d: got grant=%b valid=%b data=%h expected 10 1 %h", i, o_grant, o_mv, o_md[31:0], mk_data(1, 0, exp_beat[i]) & 512'hFFFFFFFF); end
            checks++; if (o_ml !== (exp_beat[i] == 2) || o_s1r !== n_ready || o_s0r !== 1'b0) begin errors++; $display("FAIL stall_hs%0d: got last=%b s1r=%b s0r=%b expected %b %b 0", i, o_ml, o_s1r, o_s0r, (exp_beat[i] == 2), n_ready); end
            if (i == 4) begin
                checks++; if (o_pc1 !== base) begin errors++; $display("FAIL stall_count_early: got %0d expected %0d", o_pc1, base); end
            end
        end
        n_ready = 1'b1;
        cycle();
        checks++; if (o_pc1 !== base + 1 || o_grant !== 2'b00) begin errors++; $display("FAIL stall_count: got %0d grant=%b expected %0d 00", o_pc1, o_grant, base + 1); end
    endtask

    task automatic test_enable();
        logic [31:0] base0;
        int viol;
        src_clear();
        base0 = o_pc0;
        n_en = 1'b1; n_ready = 1'b1; n_gap = 0;
        pkts_left[0] = 1; len[0] = 4;
        pkts_left[1] = 1; len[1] = 1;
        cycle();
        for (int i = 0; i < 4; i++) begin
            if (i == 1) n_en = 1'b0;
            cycle();
            checks++; if (o_grant !== 2'b01 || o_md !== mk_data(0, 0, i)) begin errors++; $display("FAIL en_beat%0d: got grant=%b expected 01 with s0 beat", i, o_grant); end
        end
        viol = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (o_grant !== 2'b00 || o_s1r !== 1'b0 || o_mv !== 1'b0) viol++;
        end
        checks++; if (viol != 0) begin errors++; $display("FAIL en_hold_idle: got %0d granted cycles expected 0", viol); end
        checks++; if (o_pc0 !== base0 + 1) begin errors++; $display("FAIL en_count: got %0d expected %0d", o_pc0, base0 + 1); end
        n_en = 1'b1;
        cycle();
        checks++; if (o_grant !== 2'b00) begin errors++; $display("FAIL en_req_cycle: got %b expected 00", o_grant); end
        cycle();
        checks++; if (o_grant !== 2'b10 || o_mv !== 1'b1 || o_md !== mk_data(1, 0, 0)) begin errors++; $display("FAIL en_regrant: got grant=%b valid=%b expected 10 1", o_grant, o_mv); end
        cycle();
    endtask

    task automatic test_reset_midpacket();
        src_clear();
        n_en = 1'b1; n_ready = 1'b1; n_gap = 0;
        pkts_left[0] = 1; len[0] = 1;
        cycle(); cycle(); cycle();
        src_clear();
        pkts_left[0] = 1; len[0] = 4;
        cycle();
        cycle();
        n_rst = 1'b0;
        cycle();
        n_rst = 1'b1;
        src_clear();
        cycle();
        checks++; if (o_grant !== 2'b00 || o_s0r !== 1'b0 || o_s1r !== 1'b0 || o_mv !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: got grant=%b s0r=%b s1r=%b valid=%b expected 00 0 0 0", o_grant, o_s0r, o_s1r, o_mv); end
        checks++; if (o_pc0 !== 0 || o_pc1 !== 0) begin errors++; $display("FAIL rstmid_counts: got %0d %0d expected 0 0", o_pc0, o_pc1); end
        pkts_left[0] = 1; len[0] = 1;
        pkts_left[1] = 1; len[1] = 1;
        cycle();
        cycle();
        checks++; if (o_grant !== 2'b01 || o_mv !== 1'b1 || o_md !== mk_data(0, 0, 0)) begin errors++; $display("FAIL rstmid_tie: got grant=%b valid=%b expected 01 1", o_grant, o_mv); end
        cycle(); cycle();
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; m_axis_tready = 1'b0; gap_cycles = '0;
        bad_ready = 0; cyc = 0;
        src_clear();
        drive_sources();
        test_reset();
        test_single_packet();
        test_back_to_back();
        test_gap();
        test_stall();
        test_enable();
        test_reset_midpacket();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/udp_tx_pkt_arbiter.md
Name: udp_tx_pkt_arbiter

Overview:
- Shares the single 512-bit UDP TX AXI-Stream path between two packet sources: source 0 is XDMA H2C host traffic, source 1 is the on-chip perf-monitor packet generator.
- Packet-atomic round-robin arbitration; once a source is granted, it keeps the grant until its tlast beat is accepted.
- Programmable idle gap between packets for rate pacing.
- Sits in front of the cross-die AXIS buffer that feeds the UDP/CMAC TX wrapper.

Parameters:
- TDATA_WIDTH, 512, AXIS data width
- TKEEP_WIDTH, 64, AXIS keep width (TDATA_WIDTH/8)
- TUSER_WIDTH, 1, AXIS user width
- CNT_WIDTH, 32, width of gap and packet counters

Ports:
- CLK  input  1  sole clock (xdma_axi_aclk domain)
- RST_N  input  1  reset; synchronous, active-low
- enable  input  1  1 = new grants allowed; 0 = finish the current packet, then hold IDLE
- gap_cycles  input  CNT_WIDTH  idle cycles inserted after each packet; sampled on the accepted tlast beat
- s0_axis_tvalid/tready/tlast  in/out/in  1  source 0 handshake
- s0_axis_tdata/tkeep/tuser  input  TDATA/TKEEP/TUSER  source 0 payload
- s1_axis_* (same set)  source 1
- m_axis_tvalid/tready/tlast  out/in/out  1  merged output handshake
- m_axis_tdata/tkeep/tuser  output  TDATA/TKEEP/TUSER  merged payload
- grant_out  output  2  one-hot current owner; 0 when not BUSY
- pkt_count0  output  CNT_WIDTH  tlast beats forwarded from s0; wraps
- pkt_count1  output  CNT_WIDTH  tlast beats forwarded from s1; wraps

Behaviour:
- Reset (RST_N=0 at a CLK edge), regardless of current state:
  - state=IDLE, grant_out=0, last_grant=1 (so s0 wins the first tie), gap counter=0, pkt_count0/1=0.
  - m_axis_tvalid=0, s0/s1_axis_tready=0, m_axis_tdata/tkeep/tuser/tlast=0.
  - A packet in flight is abandoned; nothing is flushed.
- States: IDLE, BUSY, GAP.
- IDLE:
  - if enable and exactly one s*_tvalid=1: grant that source, go to BUSY.
  - if enable and both valid: grant the source != last_grant, go to BUSY.
  - Decision is registered; the first beat can transfer in the cycle after the request is seen at the earliest, so arbitration latency is 1 cycle.
  - Both readies = 0 in IDLE.
- BUSY, owner k:
  - Datapath is a zero-latency combinational mux.
  - m_tvalid = sk_tvalid; sk_tready = m_tready; m_tdata/tkeep/tuser/tlast = sk_*.
  - Non-owner tready = 0.
  - A beat transfers when m_tvalid & m_tready.
  - On a transfer with tlast=1:
    - pkt_countk += 1 (wraps at 2^CNT_WIDTH) and last_grant=k.
    - if gap_cycles==0: go to IDLE.
    - else: load gap counter with gap_cycles and go to GAP.
- enable drop mid-packet: no effect until the tlast beat is accepted.
- GAP:
  - Both readies 0, m_tvalid=0.
  - Counter decrements each cycle; go to IDLE when the counter reaches 1.
  - GAP therefore lasts exactly gap_cycles cycles.
  - Changes to gap_cycles during GAP are ignored.
- Outputs outside BUSY: m_axis_tdata/tkeep/tuser/tlast are 0.
- Stall in BUSY: m_tready=0 holds all outputs stable (AXIS rule); the source must hold its own data.
- Single-beat packet (tvalid & tlast on first beat): BUSY lasts 1 cycle when m_tready=1.
- Back-to-back with gap_cycles=0 and both sources valid:
  - grants alternate s0, s1, s0, ...
  - 1 IDLE cycle between packets (known bandwidth cost).
- Owner deasserts tvalid mid-packet: remain BUSY with owner; the other source is never granted mid-packet.
- AXIS protocol is not checked; tkeep is passed through unmodified.

Test Plan:
- Reset then s0 sends a 4-beat packet, m_tready=1, gap=0 -> request at cycle 0, beats appear at m on cycles 1-4 with data identical to s0; pkt_count0=1; grant_out 01 during cycles 1-4, 00 at cycle 5.
- s0 and s1 both continuously valid, 2-beat packets, gap=0 -> m packet order s0,s1,s0,s1; after 8 packets pkt_count0=4 and pkt_count1=4; s1 tready is never 1 while grant_out=01.
- gap_cycles=5, s0 sends 1-beat packets continuously -> exactly 5 cycles of m_tvalid=0 in GAP plus 1 IDLE cycle between packets, i.e. one packet every 7 cycles.
- m_tready toggles 1,0,1,0 during a 3-beat s1 packet -> m outputs stable while tready=0; 3 beats delivered in order; pkt_count1 increments once, on the tlast beat only.
- enable cleared at the 2nd of 4 beats -> packet completes; no new grant while enable=0 even though s1 is valid; grant issued 1 cycle after enable returns to 1.
- RST_N=0 for one cycle at beat 2 of 4 -> next cycle grant_out=0, all readies 0, counters 0, state IDLE; s0 wins the next tie.
